// File: rtl/midi_pkg.sv
// Shared MIDI constants and the message FSM state encoding used by
// gpio_midi_encoder.
package midi_pkg;

    localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
    localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATUS = 2'd1,
        ST_NOTE   = 2'd2,
        ST_VEL    = 2'd3
    } midi_state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus tick-sampled debouncer for a bank of keys.
// Ports: clk, rst (async, active high), keys_i (raw), key_state (debounced).
module key_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] keys_i,
    output logic [WIDTH-1:0] key_state
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] samp_q, samp_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tick;
    logic [WIDTH-1:0] agree;

    assign tick      = (cnt_q == CNT_MAX);
    // A key is stable when this sample matches the previous one.
    assign agree     = ~(sync2_q ^ samp_q);
    assign key_state = state_q;

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        samp_d  = samp_q;
        state_d = state_q;
        if (tick) begin
            samp_d  = sync2_q;
            state_d = (state_q & ~agree) | (sync2_q & agree);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= keys_i;
            sync2_q <= sync1_q;
            samp_q  <= samp_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_midi_encoder.sv
// Turns debounced key press/release events into 3-byte MIDI Note-On/Off
// messages on a valid/ready byte stream.
// Ports: clk, rst (async, active high), keys_i[7:0] raw keys,
// key_state[7:0] debounced levels, tx_data/tx_valid/tx_ready byte stream.
module gpio_midi_encoder
    import midi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CHANNEL         = 0,
    parameter int BASE_NOTE       = 60,
    parameter int VELOCITY        = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keys_i,
    output logic [7:0] key_state,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam logic [3:0] CHAN = 4'(CHANNEL);
    localparam logic [6:0] BASE = 7'(BASE_NOTE);
    localparam logic [7:0] VEL  = {1'b0, 7'(VELOCITY)};

    midi_state_e state_q, state_d;
    logic [7:0]  reported_q, reported_d;
    logic [6:0]  note_q, note_d;
    logic        on_q, on_d;
    logic [7:0]  pending;
    logic [2:0]  idx;
    logic        found;
    logic        xfer;

    key_debounce #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .keys_i    (keys_i),
        .key_state (key_state)
    );

    // A press undone by a release before service cancels itself here.
    assign pending  = key_state ^ reported_q;
    assign tx_valid = (state_q != ST_IDLE);
    assign xfer     = tx_valid && tx_ready;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        reported_d = reported_q;
        note_d     = note_q;
        on_d       = on_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    note_d          = BASE + {4'b0, idx};
                    on_d            = key_state[idx];
                    reported_d[idx] = key_state[idx];
                    state_d         = ST_STATUS;
                end
            end
            ST_STATUS: if (xfer) state_d = ST_NOTE;
            ST_NOTE:   if (xfer) state_d = ST_VEL;
            ST_VEL:    if (xfer) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        unique case (state_q)
            ST_STATUS: tx_data = (on_q ? MIDI_NOTE_ON : MIDI_NOTE_OFF) | {4'h0, CHAN};
            ST_NOTE:   tx_data = {1'b0, note_q};
            ST_VEL:    tx_data = on_q ? VEL : 8'h00;
            default:   tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            reported_q <= '0;
            note_q     <= '0;
            on_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            reported_q <= reported_d;
            note_q     <= note_d;
            on_q       <= on_d;
        end
    end

endmodule

// File: tb/tb_gpio_midi_encoder.sv
// Scoreboard bench for gpio_midi_encoder: directed key patterns push
// expected bytes; a monitor pops and compares on every transfer.
module tb_gpio_midi_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] keys_i = 8'h00;
    logic [7:0] key_state;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         xfer_cyc[$];

    gpio_midi_encoder #(
        .DEBOUNCE_CYCLES (4),
        .CHANNEL         (0),
        .BASE_NOTE       (60),
        .VELOCITY        (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keys_i    (keys_i),
        .key_state (key_state),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            xfer_cyc.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte: got %0h expected none", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    n_fail++;
                    $display("FAIL byte: got %0h expected %0h", tx_data, e);
                end
            end
        end
    end

    task automatic push_msg(input logic on, input logic [7:0] note);
        exp_q.push_back(on ? 8'h90 : 8'h80);
        exp_q.push_back(note);
        exp_q.push_back(on ? 8'd100 : 8'h00);
    endtask

    task automatic wait_key(input string name, input logic [7:0] v,
                            input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (key_state === v) ok = 1;
        end
        check(name, key_state, v);
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tx_valid) ok = 1;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (tx_valid) ok = 1;
        end
        check("valid_rise", tx_valid, 1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit idle_ok;
        bit held_ok;

        // Reset state
        step(3);
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_keys", key_state, 8'h00);
        rst = 1'b0;

        // Idle with no keys
        idle_ok = 1;
        repeat (100) begin
            @(negedge clk);
            if (tx_valid !== 0 || key_state !== 0 || tx_data !== 0) idle_ok = 0;
        end
        check("idle_quiet", idle_ok, 1);

        // Key 0 press and release, back-to-back bytes
        step(1);
        tx_ready = 1'b1;
        xfer_cyc.delete();
        push_msg(1, 8'h3C);
        keys_i = 8'h01;
        wait_key("key0_on", 8'h01, 12);
        wait_drain("key0_on_msg", 40);
        check("on_xfers", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3)
            check("on_consec", xfer_cyc[2] - xfer_cyc[0], 2);
        step(1);
        push_msg(0, 8'h3C);
        keys_i = 8'h00;
        wait_key("key0_off", 8'h00, 12);
        wait_drain("key0_off_msg", 40);

        // Short glitch on key 1 must be rejected
        step(1);
        keys_i = 8'h02;
        step(2);
        keys_i = 8'h00;
        held_ok = 1;
        repeat (30) begin
            @(negedge clk);
            if (key_state !== 8'h00) held_ok = 0;
        end
        check("glitch_reject", held_ok, 1);

        // Four keys at once, ascending order, one idle cycle between
        step(1);
        xfer_cyc.delete();
        push_msg(1, 8'h3D);
        push_msg(1, 8'h3F);
        push_msg(1, 8'h41);
        push_msg(1, 8'h43);
        keys_i = 8'hAA;
        wait_key("multi_on", 8'hAA, 12);
        wait_drain("multi_on_msg", 60);
        check("multi_xfers", xfer_cyc.size(), 12);
        if (xfer_cyc.size() == 12)
            check("idle_gap", xfer_cyc[3] - xfer_cyc[2], 2);
        step(1);
        push_msg(0, 8'h3D);
        push_msg(0, 8'h3F);
        push_msg(0, 8'h41);
        push_msg(0, 8'h43);
        keys_i = 8'h00;
        wait_key("multi_off", 8'h00, 12);
        wait_drain("multi_off_msg", 60);

        // Backpressure during NOTE byte
        step(1);
        tx_ready = 1'b0;
        push_msg(1, 8'h3C);
        keys_i = 8'h01;
        wait_valid(20);
        step(1);
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;
        held_ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid !== 1 || tx_data !== 8'h3C) held_ok = 0;
        end
        check("stall_hold", held_ok, 1);
        check("stall_data", tx_data, 8'h3C);
        step(1);
        tx_ready = 1'b1;
        wait_drain("stall_msg", 20);
        step(1);
        push_msg(0, 8'h3C);
        keys_i = 8'h00;
        wait_drain("stall_off_msg", 40);

        // Key 3 pressed then released while a message is stalled
        step(1);
        tx_ready = 1'b0;
        push_msg(1, 8'h3C);
        keys_i = 8'h01;
        wait_valid(20);
        step(1);
        keys_i = 8'h09;
        wait_key("k3_on", 8'h09, 12);
        step(1);
        keys_i = 8'h01;
        wait_key("k3_off", 8'h01, 12);
        step(1);
        tx_ready = 1'b1;
        wait_drain("netzero_msg", 20);
        repeat (20) @(negedge clk);
        check("netzero_none", tx_valid, 0);

        // Reset while the Note-Off STATUS byte is pending
        step(1);
        tx_ready = 1'b0;
        keys_i = 8'h00;
        wait_valid(20);
        check("rst_status_byte", tx_data, 8'h80);
        step(1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", tx_valid, 0);
        check("rst_mid_data", tx_data, 8'h00);
        check("rst_mid_keys", key_state, 8'h00);
        step(2);
        rst = 1'b0;
        tx_ready = 1'b1;
        idle_ok = 1;
        repeat (30) begin
            @(negedge clk);
            if (tx_valid !== 0) idle_ok = 0;
        end
        check("rst_abandon", idle_ok, 1);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
